imm_ext_stage: RTL and testbench

//  Registered immediate-generation stage between fetch/decode and execute. Decodes the opcode of
//  an incoming instruction, produces the extended immediate for all MIPS immediate forms
//  (zero, sign, LUI, shamt, branch offset, jump target) plus the branch target.

---
 rtl/mips_imm_pkg.sv | 34 +++
 rtl/imm_ext_decode.sv | 82 ++++++++
 rtl/imm_ext_stage.sv | 108 ++++++++++
 tb/tb_imm_ext_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_imm_pkg
//  Description : Opcode constants and the immediate-mode encoding shared by
//                the immediate-generation stage and its decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_imm_pkg;

  // Primary opcodes (instr[31:26]) that select a non-default immediate form
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;

  typedef enum logic [2:0] {
    IMM_ZERO   = 3'd0,
    IMM_SIGN   = 3'd1,
    IMM_LUI    = 3'd2,
    IMM_SHAMT  = 3'd3,
    IMM_BRANCH = 3'd4,
    IMM_JUMP   = 3'd5
  } imm_mode_t;

endpackage
`default_nettype wire

// File: rtl/imm_ext_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_decode
//  Description : Combinational immediate generator. Classifies the opcode and
//                builds the extended immediate and (for control transfers)
//                the branch/jump target.
//  Ports       : instr     [31:0]      instruction word
//                pc_plus4  [DATA_W-1:0] PC of instr + 4
//                imm       [DATA_W-1:0] extended immediate
//                imm_mode  imm_mode_t   selected immediate form
//                br_target [DATA_W-1:0] branch/jump target, 0 otherwise
//  Revision    : 1.0  initial release
// ============================================================================
module imm_ext_decode
  import mips_imm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_plus4,
  output logic [DATA_W-1:0] imm,
  output imm_mode_t         imm_mode,
  output logic [DATA_W-1:0] br_target
);

  logic [5:0]        w_opcode;
  logic [IMM_W-1:0]  w_field;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_zext;
  logic [DATA_W-1:0] w_lui;
  logic [DATA_W-1:0] w_shamt;
  logic [DATA_W-1:0] w_br_off;
  logic [DATA_W-1:0] w_jump_off;
  logic [DATA_W-1:0] w_jump_tgt;

  assign w_opcode   = instr[31:26];
  assign w_field    = instr[IMM_W-1:0];
  assign w_sext     = {{(DATA_W-IMM_W){w_field[IMM_W-1]}}, w_field};
  assign w_zext     = {{(DATA_W-IMM_W){1'b0}}, w_field};
  // LUI: field lands just above IMM_W zero bits; on wide datapaths the bits
  // above it replicate the field's sign, as a 32-bit lui would on a 64-bit core.
  assign w_lui      = {w_sext[DATA_W-IMM_W-1:0], {IMM_W{1'b0}}};
  assign w_shamt    = {{(DATA_W-5){1'b0}}, instr[10:6]};
  assign w_br_off   = {w_sext[DATA_W-3:0], 2'b00};
  assign w_jump_off = {{(DATA_W-28){1'b0}}, instr[25:0], 2'b00};
  // Jump stays inside the 256 MB region of the delay-slot PC.
  assign w_jump_tgt = {pc_plus4[DATA_W-1:28], instr[25:0], 2'b00};

  always_comb begin
    imm       = w_sext;
    imm_mode  = IMM_SIGN;
    br_target = '0;
    case (w_opcode)
      OP_ANDI, OP_ORI, OP_XORI: begin
        imm      = w_zext;
        imm_mode = IMM_ZERO;
      end
      OP_LUI: begin
        imm      = w_lui;
        imm_mode = IMM_LUI;
      end
      OP_RTYPE: begin
        imm      = w_shamt;
        imm_mode = IMM_SHAMT;
      end
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        imm       = w_br_off;
        imm_mode  = IMM_BRANCH;
        br_target = pc_plus4 + w_br_off;
      end
      OP_J, OP_JAL: begin
        imm       = w_jump_off;
        imm_mode  = IMM_JUMP;
        br_target = w_jump_tgt;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_ext_stage.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_stage
//  Description : Registered immediate-generation pipeline stage with a
//                two-entry (main + skid) ready/valid buffer. One cycle of
//                latency, full throughput, no combinational handshake paths.
//  Ports       : clk, rst_n (async assert, active low), flush (sync drop)
//                in_valid/in_ready, instr[31:0], pc_plus4[DATA_W-1:0]
//                out_valid/out_ready, imm, imm_mode, br_target
//  Revision    : 1.0  initial release
// ============================================================================
module imm_ext_stage
  import mips_imm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_plus4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm,
  output imm_mode_t         imm_mode,
  output logic [DATA_W-1:0] br_target
);

  logic [DATA_W-1:0] w_dec_imm;
  imm_mode_t         w_dec_mode;
  logic [DATA_W-1:0] w_dec_tgt;

  imm_ext_decode #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_decode (
    .instr     (instr),
    .pc_plus4  (pc_plus4),
    .imm       (w_dec_imm),
    .imm_mode  (w_dec_mode),
    .br_target (w_dec_tgt)
  );

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_imm;
  imm_mode_t         r_main_mode;
  logic [DATA_W-1:0] r_main_tgt;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_imm;
  imm_mode_t         r_skid_mode;
  logic [DATA_W-1:0] r_skid_tgt;

  logic w_accept;
  logic w_main_free;

  assign in_ready    = ~r_skid_valid;
  assign w_accept    = in_valid & ~r_skid_valid;
  // Main register can take new data this edge: empty, or its entry leaves now.
  assign w_main_free = ~r_main_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main_imm   <= '0;
      r_main_mode  <= IMM_ZERO;
      r_main_tgt   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_mode  <= IMM_ZERO;
      r_skid_tgt   <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        // Skid is older than anything upstream; in_ready was low, so no accept.
        r_main_valid <= 1'b1;
        r_main_imm   <= r_skid_imm;
        r_main_mode  <= r_skid_mode;
        r_main_tgt   <= r_skid_tgt;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_imm   <= w_dec_imm;
        r_main_mode  <= w_dec_mode;
        r_main_tgt   <= w_dec_tgt;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      // Main is stalled: park the new entry; in_ready falls next cycle.
      r_skid_valid <= 1'b1;
      r_skid_imm   <= w_dec_imm;
      r_skid_mode  <= w_dec_mode;
      r_skid_tgt   <= w_dec_tgt;
    end
  end

  assign out_valid = r_main_valid;
  assign imm       = r_main_imm;
  assign imm_mode  = r_main_mode;
  assign br_target = r_main_tgt;

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_ext_stage
//  Description : Scoreboard bench for imm_ext_stage. Accepted inputs are
//                turned into expected results by a reference model and
//                queued; a monitor pops and compares each output transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_ext_stage;
  import mips_imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [63:0] pc64;

  logic        in_ready, out_valid;
  logic [31:0] imm, br_target;
  imm_mode_t   imm_mode;

  logic        in_ready64, out_valid64;
  logic [63:0] imm64, br_target64;
  imm_mode_t   imm_mode64;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] mode;
    logic [63:0] tgt;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  assign pc64 = {32'h0, pc};

  imm_ext_stage #(.DATA_W(32), .IMM_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_plus4(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .imm_mode(imm_mode), .br_target(br_target)
  );

  imm_ext_stage #(.DATA_W(64), .IMM_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .pc_plus4(pc64),
    .out_valid(out_valid64), .out_ready(out_ready),
    .imm(imm64), .imm_mode(imm_mode64), .br_target(br_target64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic on the instruction fields, result reduced
  // modulo 2^dw.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [63:0] p, input int dw);
    exp_t   e;
    longint s;
    longint mask;
    int     op;
    op   = int'(ins[31:26]);
    mask = (dw == 64) ? -64'sd1 : 64'h0000_0000_FFFF_FFFF;
    s    = ins[15] ? longint'(ins[15:0]) - 65536 : longint'(ins[15:0]);
    e.tgt = 0;
    if (op == 12 || op == 13 || op == 14) begin
      e.imm = 64'(ins[15:0]);  e.mode = 0;
    end else if (op == 15) begin
      e.imm = (s * 65536) & mask;  e.mode = 2;
    end else if (op == 0) begin
      e.imm = 64'(ins[10:6]);  e.mode = 3;
    end else if (op == 1 || (op >= 4 && op <= 7)) begin
      e.imm = (s * 4) & mask;  e.mode = 4;
      e.tgt = (longint'(p) + longint'(e.imm)) & mask;
    end else if (op == 2 || op == 3) begin
      e.imm = longint'(ins[25:0]) * 4;  e.mode = 5;
      e.tgt = ((longint'(p) & mask) / 268435456) * 268435456 + longint'(e.imm);
    end else begin
      e.imm = s & mask;  e.mode = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 15))
      0: op = 6'h00;  1: op = 6'h01;  2: op = 6'h02;  3: op = 6'h03;
      4: op = 6'h04;  5: op = 6'h05;  6: op = 6'h06;  7: op = 6'h07;
      8: op = 6'h08;  9: op = 6'h0C; 10: op = 6'h0D; 11: op = 6'h0E;
      12: op = 6'h0F; 13: op = 6'h23; 14: op = 6'h2B;
      default: op = 6'($urandom);
    endcase
    return {op, 26'($urandom)};
  endfunction

  // Monitor: output transfers are checked before the same cycle's flush or
  // input transfer is applied to the expected-queue.
  logic        hold_pending = 1'b0;
  logic [63:0] h_imm, h_mode, h_tgt;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_imm", 64'(imm), h_imm);
        chk("hold_mode", 64'(imm_mode), h_mode);
        chk("hold_tgt", 64'(br_target), h_tgt);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'(imm), 64'hDEAD_0000_0000_0000);
        end else begin
          e = q.pop_front();
          chk("sb_imm", 64'(imm), e.imm);
          chk("sb_mode", 64'(imm_mode), e.mode);
          chk("sb_tgt", 64'(br_target), e.tgt);
        end
      end
      hold_pending = out_valid && !out_ready && !flush;
      h_imm  = 64'(imm);
      h_mode = 64'(imm_mode);
      h_tgt  = 64'(br_target);
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(ref_model(instr, 64'(pc), 32));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    instr    = i;
    pc       = p;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_mode", 64'(imm_mode), 64'd0);
    chk("rst_tgt", 64'(br_target), 64'd0);
    rst_n = 1'b1;
    tick();

    // ori: zero extension, one cycle latency
    out_ready = 1'b1;
    drive(32'h3402_8001, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_imm", 64'(imm), 64'h0000_8001);
    chk("t1_mode", 64'(imm_mode), 64'd0);

    // lui then addi back to back
    drive(32'h3C01_1234, 32'h0);
    tick();
    chk("t2_lui_imm", 64'(imm), 64'h1234_0000);
    chk("t2_lui_mode", 64'(imm_mode), 64'd2);
    drive(32'h2001_FFFC, 32'h0);
    tick();
    chk("t2_addi_valid", 64'(out_valid), 64'd1);
    chk("t2_addi_imm", 64'(imm), 64'hFFFF_FFFC);
    chk("t2_addi_mode", 64'(imm_mode), 64'd1);

    // branch and jump, both datapath widths
    drive(32'h1000_FFFF, 32'h0040_0010);
    tick();
    chk("t3_beq_imm", 64'(imm), 64'hFFFF_FFFC);
    chk("t3_beq_tgt", 64'(br_target), 64'h0040_000C);
    chk("t3_beq_mode", 64'(imm_mode), 64'd4);
    chk("t3_beq_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t3_beq_tgt64", br_target64, 64'h0000_0000_0040_000C);
    drive(32'h0810_0004, 32'h9000_0000);
    tick();
    chk("t3_j_imm", 64'(imm), 64'h0040_0010);
    chk("t3_j_tgt", 64'(br_target), 64'h9040_0010);
    chk("t3_j_mode", 64'(imm_mode), 64'd5);
    chk("t3_j_tgt64", br_target64, 64'h0000_0000_9040_0010);
    in_valid = 1'b0;
    tick();

    // stall: two captured, third held upstream, then drained in order
    out_ready = 1'b0;
    drive(32'h2001_0001, 32'h0);
    tick();
    chk("t4_ready_c1", 64'(in_ready), 64'd1);
    drive(32'h2001_0002, 32'h0);
    tick();
    chk("t4_ready_c2", 64'(in_ready), 64'd0);
    drive(32'h2001_0003, 32'h0);
    tick();
    chk("t4_ready_c3", 64'(in_ready), 64'd0);
    chk("t4_held_imm", 64'(imm), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("t4_rel_imm", 64'(imm), 64'd2);
    chk("t4_rel_ready", 64'(in_ready), 64'd1);
    tick();
    chk("t4_third_imm", 64'(imm), 64'd3);
    in_valid = 1'b0;
    tick();

    // flush with skid full
    out_ready = 1'b0;
    drive(32'h2001_0004, 32'h0);
    tick();
    drive(32'h2001_0005, 32'h0);
    tick();
    chk("t5_skid_full", 64'(in_ready), 64'd0);
    drive(32'h2001_0006, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_flush_valid", 64'(out_valid), 64'd0);
    chk("t5_flush_ready", 64'(in_ready), 64'd1);
    // flush overriding an input transfer that would have been accepted
    drive(32'h2001_0007, 32'h0);
    tick();
    drive(32'h2001_0008, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_flush2_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("t5_no_ghost", 64'(out_valid), 64'd0);

    // asynchronous reset between edges during a stall
    out_ready = 1'b0;
    drive(32'h2001_0009, 32'h0);
    tick();
    drive(32'h2001_000A, 32'h0);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_ready", 64'(in_ready), 64'd1);
    chk("t6_async_imm", 64'(imm), 64'd0);
    chk("t6_async_mode", 64'(imm_mode), 64'd0);
    chk("t6_async_tgt", 64'(br_target), 64'd0);
    chk("t6_async_valid64", 64'(out_valid64), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 39) == 0);
      instr     = rand_instr();
      pc        = {$urandom} & 32'hFFFF_FFFC;
      tick();
    end

    // drain
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
